// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense scheduler: coin codes, coin values
// and the controller state encoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } vend_state_e;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-lane saturating stock counters; a vend decrement and a restock may land on
// the same lane in the same cycle.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_i,
    input  logic [LANE_W-1:0]    dec_lane_i,
    input  logic                 refill_i,
    input  logic [LANE_W-1:0]    refill_lane_i,
    input  logic [STOCK_W-1:0]   refill_cnt_i,
    input  logic [LANE_W-1:0]    query_lane_i,
    output logic [NUM_LANES-1:0] zero_o,
    output logic                 avail_o
);

    localparam int PAD_W = 1 << LANE_W;
    localparam logic [STOCK_W:0] SAT = {1'b0, {STOCK_W{1'b1}}};

    logic [PAD_W-1:0] zero_pad;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic               dec_hit;
        logic               ref_hit;
        logic [STOCK_W:0]   sum;
        logic [STOCK_W-1:0] stock_q;
        logic [STOCK_W-1:0] stock_d;

        assign dec_hit = dec_i && (dec_lane_i == LANE_W'(g));
        assign ref_hit = refill_i && (refill_lane_i == LANE_W'(g));
        // Decrement is only issued for nonzero stock, so the subtraction never wraps.
        assign sum     = {1'b0, stock_q}
                       + (ref_hit ? {1'b0, refill_cnt_i} : '0)
                       - {{STOCK_W{1'b0}}, dec_hit};
        assign stock_d = (sum > SAT) ? SAT[STOCK_W-1:0] : sum[STOCK_W-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                stock_q <= STOCK_W'(INIT_STOCK);
            end else begin
                stock_q <= stock_d;
            end
        end

        assign zero_o[g] = (stock_q == '0);
    end

    // Lanes beyond NUM_LANES read as empty so an invalid selection is refused.
    always_comb begin
        zero_pad                 = '1;
        zero_pad[NUM_LANES-1:0]  = zero_o;
    end

    assign avail_o = ~zero_pad[query_lane_i];

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Vending controller: coin credit, lane selection arbitration, timed dispense and
// unit-coin change payout.
//
//   state       | meaning
//   ST_IDLE     | accepting coins, selections and cancel
//   ST_DISPENSE | one lane motor enabled for DISPENSE_CYC cycles
//   ST_CHANGE   | paying one unit coin per cycle until credit is 0
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = 2,
    parameter int PRICE        = 4,
    parameter int MAX_CREDIT   = 20,
    parameter int CREDIT_W     = 5,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 2,
    parameter int DISPENSE_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           coin_in,
    input  logic                 sel_valid,
    input  logic [LANE_W-1:0]    sel_lane,
    input  logic                 cancel,
    input  logic                 refill_valid,
    input  logic [LANE_W-1:0]    refill_lane,
    input  logic [STOCK_W-1:0]   refill_cnt,
    output logic                 coin_reject,
    output logic                 err_pulse,
    output logic                 busy,
    output logic [NUM_LANES-1:0] dispense_en,
    output logic                 change_out,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_LANES-1:0] sold_out
);

    localparam int CSUM_W = CREDIT_W + 1;
    localparam int CNT_W  = $clog2(DISPENSE_CYC) + 1;
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CSUM_W-1:0]   MAX_C    = CSUM_W'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DISPENSE_CYC - 1);

    vend_state_e            state_q, state_d;
    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic                   coin_reject_q, coin_reject_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   busy_q;
    logic                   change_out_q;
    logic [NUM_LANES-1:0]   dispense_en_q, dispense_en_d;
    logic [CSUM_W-1:0]      credit_sum;
    logic                   coin_present;
    logic                   dec_en;
    logic                   lane_avail;

    assign coin_present = (coin_in != COIN_NONE);
    assign credit_sum   = {1'b0, credit_q} + CSUM_W'(coin_value(coin_in));

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        cnt_d         = cnt_q;
        lane_d        = lane_q;
        coin_reject_d = 1'b0;
        err_pulse_d   = 1'b0;
        dec_en        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    coin_reject_d = coin_present;
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_present;
                    if (lane_avail && (credit_q >= PRICE_C)) begin
                        credit_d = credit_q - PRICE_C;
                        dec_en   = 1'b1;
                        lane_d   = sel_lane;
                        cnt_d    = CNT_LAST;
                        state_d  = ST_DISPENSE;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end else if (coin_present) begin
                    if (credit_sum <= MAX_C) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_present;
                err_pulse_d   = sel_valid;
                if (cnt_q == '0) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_present;
                err_pulse_d   = sel_valid;
                credit_d      = credit_q - 1'b1;
                if (credit_q == CREDIT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dispense_en_d = '0;
        if (state_d == ST_DISPENSE) begin
            dispense_en_d = NUM_LANES'(1) << lane_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            cnt_q         <= '0;
            lane_q        <= '0;
            coin_reject_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            busy_q        <= 1'b0;
            change_out_q  <= 1'b0;
            dispense_en_q <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            cnt_q         <= cnt_d;
            lane_q        <= lane_d;
            coin_reject_q <= coin_reject_d;
            err_pulse_q   <= err_pulse_d;
            busy_q        <= (state_d != ST_IDLE);
            change_out_q  <= (state_d == ST_CHANGE);
            dispense_en_q <= dispense_en_d;
        end
    end

    vend_stock_bank #(
        .NUM_LANES  (NUM_LANES),
        .LANE_W     (LANE_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk           (clk),
        .rst           (rst),
        .dec_i         (dec_en),
        .dec_lane_i    (sel_lane),
        .refill_i      (refill_valid),
        .refill_lane_i (refill_lane),
        .refill_cnt_i  (refill_cnt),
        .query_lane_i  (sel_lane),
        .zero_o        (sold_out),
        .avail_o       (lane_avail)
    );

    assign coin_reject = coin_reject_q;
    assign err_pulse   = err_pulse_q;
    assign busy        = busy_q;
    assign change_out  = change_out_q;
    assign dispense_en = dispense_en_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: directed scenarios then random traffic, all
// checked cycle by cycle against a transaction-level vending model.
module tb_vend_dispense_scheduler;

    localparam int NL = 4, LW = 2, PRICE = 4, MAXC = 20, CW = 5, SW = 4, INIT = 2, DCYC = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [1:0]    coin_in = '0;
    logic          sel_valid = 1'b0;
    logic [LW-1:0] sel_lane = '0;
    logic          cancel = 1'b0;
    logic          refill_valid = 1'b0;
    logic [LW-1:0] refill_lane = '0;
    logic [SW-1:0] refill_cnt = '0;
    logic          coin_reject, err_pulse, busy, change_out;
    logic [NL-1:0] dispense_en, sold_out;
    logic [CW-1:0] credit;

    int tests = 0;
    int fails = 0;

    // Model: credit in units, items per lane, remaining motor cycles, refund flag.
    int m_credit;
    int m_stock [NL];
    int m_disp_left;
    int m_lane;
    bit m_paying;
    bit m_rej;
    bit m_err;

    int n_busy, n_disp, n_chg;

    vend_dispense_scheduler #(
        .NUM_LANES(NL), .LANE_W(LW), .PRICE(PRICE), .MAX_CREDIT(MAXC),
        .CREDIT_W(CW), .STOCK_W(SW), .INIT_STOCK(INIT), .DISPENSE_CYC(DCYC)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid), .sel_lane(sel_lane),
        .cancel(cancel), .refill_valid(refill_valid), .refill_lane(refill_lane),
        .refill_cnt(refill_cnt), .coin_reject(coin_reject), .err_pulse(err_pulse),
        .busy(busy), .dispense_en(dispense_en), .change_out(change_out),
        .credit(credit), .sold_out(sold_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < NL; i++) m_stock[i] = INIT;
        m_disp_left = 0;
        m_lane = 0;
        m_paying = 1'b0;
        m_rej = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input int coin, input bit sv, input int sl, input bit cn,
                              input bit rv, input int rl, input int rc);
        int val;
        int dec_lane;
        int nxt;
        val = (coin == 1) ? 1 : (coin == 2) ? 2 : (coin == 3) ? 5 : 0;
        dec_lane = -1;
        m_rej = 1'b0;
        m_err = 1'b0;
        if (m_disp_left == 0 && !m_paying) begin
            if (cn) begin
                m_rej = (coin != 0);
                if (m_credit > 0) m_paying = 1'b1;
            end else if (sv) begin
                m_rej = (coin != 0);
                if (sl < NL && m_stock[sl] > 0 && m_credit >= PRICE) begin
                    m_credit -= PRICE;
                    dec_lane = sl;
                    m_lane = sl;
                    m_disp_left = DCYC;
                end else begin
                    m_err = 1'b1;
                end
            end else if (val > 0) begin
                if (m_credit + val <= MAXC) m_credit += val;
                else m_rej = 1'b1;
            end
        end else begin
            m_rej = (coin != 0);
            m_err = sv;
            if (m_disp_left > 0) begin
                m_disp_left--;
                if (m_disp_left == 0 && m_credit > 0) m_paying = 1'b1;
            end else begin
                m_credit--;
                if (m_credit == 0) m_paying = 1'b0;
            end
        end
        for (int i = 0; i < NL; i++) begin
            nxt = m_stock[i] - ((i == dec_lane) ? 1 : 0) + ((rv && rl == i) ? rc : 0);
            m_stock[i] = (nxt > SMAX) ? SMAX : nxt;
        end
    endtask

    task automatic check_outputs();
        logic [NL-1:0] exp_so;
        logic [NL-1:0] exp_de;
        for (int i = 0; i < NL; i++) exp_so[i] = (m_stock[i] == 0);
        exp_de = (m_disp_left > 0) ? NL'(1 << m_lane) : '0;
        chk("credit", 32'(credit), 32'(m_credit));
        chk("busy", 32'(busy), 32'(m_disp_left > 0 || m_paying));
        chk("dispense_en", 32'(dispense_en), 32'(exp_de));
        chk("change_out", 32'(change_out), 32'(m_paying));
        chk("coin_reject", 32'(coin_reject), 32'(m_rej));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        chk("sold_out", 32'(sold_out), 32'(exp_so));
    endtask

    task automatic step(input bit r, input int coin, input bit sv, input int sl, input bit cn,
                        input bit rv, input int rl, input int rc);
        @(negedge clk);
        rst = r;
        coin_in = 2'(coin);
        sel_valid = sv;
        sel_lane = LW'(sl);
        cancel = cn;
        refill_valid = rv;
        refill_lane = LW'(rl);
        refill_cnt = SW'(rc);
        @(posedge clk);
        if (r) model_reset();
        else model_step(coin, sv, sl, cn, rv, rl, rc);
        #1;
        check_outputs();
        n_busy += int'(busy);
        n_disp += int'(dispense_en != '0);
        n_chg  += int'(change_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_counts();
        n_busy = 0;
        n_disp = 0;
        n_chg = 0;
    endtask

    initial begin
        model_reset();
        clear_counts();

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_credit", 32'(credit), 32'd0);
        chk("reset_sold_out", 32'(sold_out), 32'd0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("coin1_credit", 32'(credit), 32'd1);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        chk("coin2_credit", 32'(credit), 32'd3);
        step(0, 3, 0, 0, 0, 0, 0, 0);
        chk("coin5_credit", 32'(credit), 32'd8);

        clear_counts();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("vend0_enable", 32'(dispense_en), 32'b0001);
        idle(8);
        chk("vend0_busy_cycles", 32'(n_busy), 32'd7);
        chk("vend0_disp_cycles", 32'(n_disp), 32'd3);
        chk("vend0_change_cycles", 32'(n_chg), 32'd4);
        chk("vend0_credit_end", 32'(credit), 32'd0);

        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("short_credit_err", 32'(err_pulse), 32'd1);
        chk("short_credit_keep", 32'(credit), 32'd3);
        clear_counts();
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(4);
        chk("cancel_change_cycles", 32'(n_chg), 32'd3);
        chk("cancel_idle", 32'(busy), 32'd0);

        for (int k = 0; k < 2; k++) begin
            step(0, 2, 0, 0, 0, 0, 0, 0);
            step(0, 2, 0, 0, 0, 0, 0, 0);
            step(0, 0, 1, 2, 0, 0, 0, 0);
            idle(DCYC + 1);
        end
        chk("lane2_sold_out", 32'(sold_out[2]), 32'd1);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0, 0);
        chk("lane2_empty_err", 32'(err_pulse), 32'd1);
        step(0, 0, 0, 0, 0, 1, 2, 5);
        chk("lane2_refilled", 32'(sold_out[2]), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(6);

        step(0, 3, 0, 0, 0, 0, 0, 0);
        step(0, 3, 0, 0, 0, 0, 0, 0);
        step(0, 3, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("credit_18", 32'(credit), 32'd18);
        step(0, 3, 0, 0, 0, 0, 0, 0);
        chk("overflow_reject", 32'(coin_reject), 32'd1);
        chk("overflow_keep", 32'(credit), 32'd18);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        chk("coin_with_sel_reject", 32'(coin_reject), 32'd1);
        chk("coin_with_sel_vend", 32'(dispense_en), 32'b0010);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        chk("coin_in_dispense_reject", 32'(coin_reject), 32'd1);
        idle(20);

        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset_dispense", 32'(dispense_en), 32'd0);
        chk("midreset_credit", 32'(credit), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_sold_out", 32'(sold_out), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            bit r, sv, cn, rv;
            int coin, sl, rl, rc;
            r    = ($urandom_range(0, 249) == 0);
            coin = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : 0;
            sv   = ($urandom_range(0, 9) < 2);
            sl   = int'($urandom_range(0, NL - 1));
            cn   = ($urandom_range(0, 29) == 0);
            rv   = ($urandom_range(0, 19) == 0);
            rl   = int'($urandom_range(0, NL - 1));
            rc   = int'($urandom_range(0, SMAX));
            step(r, coin, sv, sl, cn, rv, rl, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
